seg7_scan_driver: RTL and testbench

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

---
 rtl/seg7_pkg.sv | 30 +++
 rtl/seg7_decode.sv | 12 +
 rtl/seg7_scan_driver.sv | 117 +++++++++++
 tb/tb_seg7_scan_driver.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants, types and segment table for the eight-digit scanned seven-segment driver.
// Segment codes are high-true {g,f,e,d,c,b,a}; output polarity is applied at the driver's register stage.
package seg7_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int BCD_W      = 4;
    localparam int SEG_W      = 7;

    localparam logic [SEG_W-1:0] SEG_OFF = 7'h00;

    // Index 15 is leftmost; codes 10-15 are dark so a corrupt nibble never shows a misleading glyph.
    localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
        7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00,
        7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
        7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    typedef logic [2:0] idx_t;

    typedef struct packed {
        logic [NUM_DIGITS*BCD_W-1:0] digits;
        logic [NUM_DIGITS-1:0]       dp_mask;
        logic                        blank_lz;
    } frame_t;

    function automatic logic [SEG_W-1:0] seg_lookup(input logic [BCD_W-1:0] bcd);
        return SEG_TABLE[bcd];
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Purpose: BCD nibble to high-true {g,f,e,d,c,b,a} segment pattern.
// Latency: purely combinational. Backpressure: none.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [BCD_W-1:0] bcd,
    output logic [SEG_W-1:0] seg
);

    assign seg = seg_lookup(bcd);

endmodule

// File: rtl/seg7_scan_driver.sv
// Purpose: time-multiplexes eight BCD digits onto one seven-segment bus with dp and leading-zero blanking.
// Latency: an/seg/dp registered one cycle after idx; loads take effect at the next 7->0 wrap. Backpressure: none, load always accepted.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_DIGITS*BCD_W-1:0] digits,
    input  logic                        load,
    input  logic [NUM_DIGITS-1:0]       dp_mask,
    input  logic                        blank_lz,
    output logic [NUM_DIGITS-1:0]       an,
    output logic [SEG_W-1:0]            seg,
    output logic                        dp,
    output logic                        frame_done
);

    localparam int                 PRE_W      = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PRE_W-1:0]   PRE_MAX    = PRE_W'(SCAN_DIV - 1);
    localparam idx_t               IDX_LAST   = 3'(NUM_DIGITS - 1);
    localparam logic [SEG_W-1:0]   SEG_OFF_LV = SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
    localparam logic               DP_OFF_LV  = SEG_ACTIVE_LOW;

    logic [PRE_W-1:0]       pre_cnt;
    idx_t                   idx;
    logic                   tick;
    logic                   wrap;
    logic                   pending;
    frame_t                 live;
    frame_t                 staging;
    frame_t                 display;
    logic [NUM_DIGITS-1:0]  lead_zero;
    logic [BCD_W-1:0]       cur_bcd;
    logic                   cur_blank;
    logic [SEG_W-1:0]       dec_seg;
    logic [SEG_W-1:0]       seg_ht;
    logic                   dp_ht;

    assign tick = (pre_cnt == PRE_MAX);
    assign wrap = tick && (idx == IDX_LAST);
    assign live = {digits, dp_mask, blank_lz};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
            idx     <= '0;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
            if (tick) begin
                idx <= idx + 1'b1;
            end
        end
    end

    // The display register only moves at the frame wrap; a load on that same edge bypasses staging.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            staging <= '0;
            display <= '0;
            pending <= 1'b0;
        end else begin
            if (load) begin
                staging <= live;
            end
            if (wrap) begin
                if (load) begin
                    display <= live;
                end else if (pending) begin
                    display <= staging;
                end
                pending <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    // lead_zero[i] is set when digits i..7 of the displayed value are all zero.
    always_comb begin : lz_scan
        logic zero_run;
        zero_run  = 1'b1;
        lead_zero = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run     = zero_run & (display.digits[i*BCD_W +: BCD_W] == '0);
            lead_zero[i] = zero_run;
        end
    end

    assign cur_bcd   = display.digits[{idx, 2'b00} +: BCD_W];
    assign cur_blank = display.blank_lz && (idx != '0) && lead_zero[idx];

    seg7_decode u_decode (
        .bcd (cur_bcd),
        .seg (dec_seg)
    );

    assign seg_ht = cur_blank ? SEG_OFF : dec_seg;
    assign dp_ht  = display.dp_mask[idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an         <= '1;
            seg        <= SEG_OFF_LV;
            dp         <= DP_OFF_LV;
            frame_done <= 1'b0;
        end else begin
            an         <= ~(NUM_DIGITS'(1) << idx);
            seg        <= SEG_ACTIVE_LOW ? ~seg_ht : seg_ht;
            dp         <= SEG_ACTIVE_LOW ? ~dp_ht : dp_ht;
            frame_done <= wrap;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver (SCAN_DIV=4, active-low segments): directed and random loads checked
// against a model that derives each cycle's expected digit, glyph and frame pulse from the edge count.
module tb_seg7_scan_driver;

    localparam int SCAN_DIV = 4;
    localparam int FRAME    = 8 * SCAN_DIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] digits = '0;
    logic        load = 1'b0;
    logic [7:0]  dp_mask = '0;
    logic        blank_lz = 1'b0;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    seg7_scan_driver #(.SCAN_DIV(SCAN_DIV), .SEG_ACTIVE_LOW(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .digits     (digits),
        .load       (load),
        .dp_mask    (dp_mask),
        .blank_lz   (blank_lz),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          edge_no;
        logic [31:0] d;
        logic [7:0]  m;
        logic        b;
    } load_t;

    load_t loads[$];
    int    edge_n = 0;
    int    checks = 0;
    int    errors = 0;

    function automatic logic [6:0] glyph(input int v);
        case (v)
            0: return 7'h3F;
            1: return 7'h06;
            2: return 7'h5B;
            3: return 7'h4F;
            4: return 7'h66;
            5: return 7'h6D;
            6: return 7'h7D;
            7: return 7'h07;
            8: return 7'h7F;
            9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    task automatic check_now();
        logic [7:0]  e_an;
        logic [6:0]  e_seg;
        logic        e_dp;
        logic        e_fd;
        logic [31:0] cd;
        logic [7:0]  cm;
        logic        cb;
        int          d;
        int          w;
        int          nib;
        if (!rst_n || edge_n == 0) begin
            e_an  = 8'hFF;
            e_seg = 7'h7F;
            e_dp  = 1'b1;
            e_fd  = 1'b0;
        end else begin
            cd = '0;
            cm = '0;
            cb = 1'b0;
            d  = ((edge_n - 1) / SCAN_DIV) % 8;
            // A load seen at edge e becomes visible after the first wrap edge (multiple of FRAME) at or after e.
            foreach (loads[i]) begin
                w = ((loads[i].edge_no + FRAME - 1) / FRAME) * FRAME;
                if (w < edge_n) begin
                    cd = loads[i].d;
                    cm = loads[i].m;
                    cb = loads[i].b;
                end
            end
            nib  = int'((cd >> (4 * d)) & 32'hF);
            e_an = ~(8'd1 << d);
            if (cb && d >= 1 && (cd >> (4 * d)) == 32'd0) e_seg = 7'h7F;
            else                                          e_seg = ~glyph(nib);
            e_dp = ~cm[d];
            e_fd = (edge_n % FRAME == 0);
        end
        checks++;
        assert (an === e_an) else begin
            errors++;
            $error("FAIL an edge=%0d observed=%h expected=%h", edge_n, an, e_an);
        end
        checks++;
        assert (seg === e_seg) else begin
            errors++;
            $error("FAIL seg edge=%0d observed=%h expected=%h", edge_n, seg, e_seg);
        end
        checks++;
        assert (dp === e_dp) else begin
            errors++;
            $error("FAIL dp edge=%0d observed=%b expected=%b", edge_n, dp, e_dp);
        end
        checks++;
        assert (frame_done === e_fd) else begin
            errors++;
            $error("FAIL frame_done edge=%0d observed=%b expected=%b", edge_n, frame_done, e_fd);
        end
    endtask

    task automatic cyc(input int n);
        load_t l;
        repeat (n) begin
            @(posedge clk);
            if (rst_n) begin
                edge_n++;
                if (load) begin
                    l.edge_no = edge_n;
                    l.d       = digits;
                    l.m       = dp_mask;
                    l.b       = blank_lz;
                    loads.push_back(l);
                end
            end
            #1;
            check_now();
        end
    endtask

    task automatic do_load(input logic [31:0] d, input logic [7:0] m, input logic b);
        digits   = d;
        dp_mask  = m;
        blank_lz = b;
        load     = 1'b1;
        cyc(1);
        load     = 1'b0;
        digits   = $urandom;
        dp_mask  = 8'($urandom);
        blank_lz = 1'($urandom);
    endtask

    initial begin
        logic [31:0] rd;
        rst_n = 1'b0;
        cyc(3);
        #2 rst_n = 1'b1;
        check_now();
        cyc(40);

        // Mid-frame load with blanking: digits 4-7 go dark next frame.
        cyc(5);
        do_load(32'h0000_1234, 8'h00, 1'b1);
        cyc(70);

        // Two loads inside one frame: last one wins.
        cyc(3);
        do_load(32'h1111_1111, 8'h00, 1'b0);
        cyc(5);
        do_load(32'h2222_2222, 8'h00, 1'b0);
        cyc(60);

        // All zeros with blanking; dp survives on blanked digit 2.
        do_load(32'h0000_0000, 8'h04, 1'b1);
        cyc(70);

        // Load coinciding with the idx 7 tick.
        while ((edge_n + 1) % FRAME != 0) cyc(1);
        do_load(32'h0000_0987, 8'h01, 1'b1);
        cyc(40);

        repeat (300) begin
            if ($urandom_range(0, 9) == 0) begin
                rd = $urandom >> (4 * $urandom_range(0, 8));
                do_load(rd, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            end else begin
                digits = $urandom;
                cyc(1);
            end
        end
        cyc(40);

        // Asynchronous reset with a load pending: everything is discarded.
        while (edge_n % FRAME != 5) cyc(1);
        do_load(32'h5555_5555, 8'hFF, 1'b0);
        cyc(2);
        #2 rst_n = 1'b0;
        #1 check_now();
        cyc(2);
        #2 rst_n = 1'b1;
        edge_n = 0;
        loads.delete();
        check_now();
        cyc(70);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
